// File: rtl/sys_timer_driver.sv
// Avalon-MM initiator that programs the interval timer, acks each timeout as a tick, and reads 32-bit snapshots.
// Bus outputs are registered from the next state, so each FSM state drives its one access; there is no waitrequest.
module sys_timer_driver #(
  parameter int TICK_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_stop,
  input  logic              snap_req,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              timer_irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic              running
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, STOP_WR,
    SNAP_WR, SNAP_RL, WAIT_L, SNAP_RH, WAIT_H
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  state_t              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                stop_pend_q, stop_pend_d;
  logic                snap_pend_q, snap_pend_d;
  logic                from_run_q, from_run_d;
  logic [1:0]          wait_q, wait_d;
  logic [15:0]         snap_lo_q, snap_lo_d;
  logic [2:0]          addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                wn_q, wn_d;
  logic [15:0]         wd_q, wd_d;
  logic                tick_q, tick_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic                sv_q, sv_d;
  logic [31:0]         sval_q, sval_d;
  logic                run_q, run_d;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    stop_pend_d = stop_pend_q | cfg_stop;
    snap_pend_d = snap_pend_q | snap_req;
    from_run_d  = from_run_q;
    wait_d      = wait_q;
    snap_lo_d   = snap_lo_q;
    cnt_d       = cnt_q;
    sv_d        = 1'b0;
    sval_d      = sval_q;

    case (state_q)
      IDLE: begin
        // A stop with nothing running is dropped, unless it races a start.
        stop_pend_d = cfg_start & cfg_stop;
        if (cfg_start) begin
          state_d  = WR_PL;
          period_d = cfg_period;
        end else if (snap_req || snap_pend_q) begin
          state_d     = SNAP_WR;
          snap_pend_d = 1'b0;
          from_run_d  = 1'b0;
        end
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTRL;
      WR_CTRL: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (stop_pend_q || cfg_stop) begin
          state_d     = STOP_WR;
          stop_pend_d = 1'b0;
        end else if (timer_irq) begin
          state_d = CLR_ST;
          cnt_d   = cnt_q + 1'b1;
        end else if (snap_pend_q || snap_req) begin
          state_d     = SNAP_WR;
          snap_pend_d = 1'b0;
          from_run_d  = 1'b1;
        end
      end
      CLR_ST:  state_d = RUN;
      STOP_WR: state_d = IDLE;
      SNAP_WR: state_d = SNAP_RL;
      SNAP_RL: begin
        state_d = WAIT_L;
        wait_d  = '0;
      end
      WAIT_L: begin
        if (wait_q == WAIT_LAST) begin
          snap_lo_d = avm_readdata;
          state_d   = SNAP_RH;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      SNAP_RH: begin
        state_d = WAIT_H;
        wait_d  = '0;
      end
      WAIT_H: begin
        if (wait_q == WAIT_LAST) begin
          sval_d  = {avm_readdata, snap_lo_q};
          sv_d    = 1'b1;
          state_d = from_run_q ? RUN : IDLE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'd0;
    tick_d = 1'b0;
    run_d  = 1'b0;
    case (state_d)
      WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_d[15:0];  run_d = 1'b1; end
      WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_q[31:16]; run_d = 1'b1; end
      WR_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0007;        run_d = 1'b1; end
      RUN:     run_d = 1'b1;
      CLR_ST:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; tick_d = 1'b1;          run_d = 1'b1; end
      STOP_WR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008;        run_d = 1'b1; end
      SNAP_WR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; run_d = from_run_d; end
      SNAP_RL: begin cs_d = 1'b1; addr_d = 3'd4; run_d = from_run_d; end
      SNAP_RH: begin cs_d = 1'b1; addr_d = 3'd5; run_d = from_run_d; end
      WAIT_L, WAIT_H: run_d = from_run_d;
      default: run_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      period_q    <= '0;
      stop_pend_q <= 1'b0;
      snap_pend_q <= 1'b0;
      from_run_q  <= 1'b0;
      wait_q      <= '0;
      snap_lo_q   <= '0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      wd_q        <= '0;
      tick_q      <= 1'b0;
      cnt_q       <= '0;
      sv_q        <= 1'b0;
      sval_q      <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      stop_pend_q <= stop_pend_d;
      snap_pend_q <= snap_pend_d;
      from_run_q  <= from_run_d;
      wait_q      <= wait_d;
      snap_lo_q   <= snap_lo_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      wd_q        <= wd_d;
      tick_q      <= tick_d;
      cnt_q       <= cnt_d;
      sv_q        <= sv_d;
      sval_q      <= sval_d;
      run_q       <= run_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wd_q;
  assign tick           = tick_q;
  assign tick_count     = cnt_q;
  assign snap_valid     = sv_q;
  assign snap_value     = sval_q;
  assign running        = run_q;

endmodule

// File: tb/tb_sys_timer_driver.sv
// Directed bench: instance A (read latency 1) runs the full flow, instance B (read latency 3) does an idle snapshot.
module tb_sys_timer_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, stop_a = 1'b0, snapreq_a = 1'b0, snapreq_b = 1'b0, irq_set = 1'b0;
  logic [31:0] period_a = '0;
  logic [31:0] cnt_model = 32'h0003_1234;

  logic [2:0]  addr_a, addr_b;
  logic        cs_a, cs_b, wn_a, wn_b, tick_a, tick_b, sv_a, sv_b, run_a, run_b;
  logic [15:0] wd_a, wd_b, tcnt_a, tcnt_b;
  logic [15:0] rd_a, rd_b, p1_b, p2_b;
  logic [31:0] sval_a, sval_b, lat_a, lat_b;
  logic        irq_a;

  sys_timer_driver #(.TICK_W(16), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .cfg_start(start_a), .cfg_period(period_a),
    .cfg_stop(stop_a), .snap_req(snapreq_a), .avm_address(addr_a),
    .avm_chipselect(cs_a), .avm_write_n(wn_a), .avm_writedata(wd_a),
    .avm_readdata(rd_a), .timer_irq(irq_a), .tick(tick_a), .tick_count(tcnt_a),
    .snap_valid(sv_a), .snap_value(sval_a), .running(run_a));

  sys_timer_driver #(.TICK_W(16), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .cfg_start(1'b0), .cfg_period(32'h0),
    .cfg_stop(1'b0), .snap_req(snapreq_b), .avm_address(addr_b),
    .avm_chipselect(cs_b), .avm_write_n(wn_b), .avm_writedata(wd_b),
    .avm_readdata(rd_b), .timer_irq(1'b0), .tick(tick_b), .tick_count(tcnt_b),
    .snap_valid(sv_b), .snap_value(sval_b), .running(run_b));

  // Timer slave models: irq cleared by a status write, snapshot latched by an addr4 write.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_a <= 1'b0; lat_a <= '0; rd_a <= 16'hDEAD;
      lat_b <= '0; p1_b <= 16'hDEAD; p2_b <= 16'hDEAD; rd_b <= 16'hDEAD;
    end else begin
      if (cs_a && !wn_a && addr_a == 3'd0) irq_a <= 1'b0;
      else if (irq_set) irq_a <= 1'b1;
      if (cs_a && !wn_a && addr_a == 3'd4) lat_a <= cnt_model;
      rd_a <= 16'hDEAD;
      if (cs_a && wn_a && addr_a == 3'd4) rd_a <= lat_a[15:0];
      if (cs_a && wn_a && addr_a == 3'd5) rd_a <= lat_a[31:16];
      if (cs_b && !wn_b && addr_b == 3'd4) lat_b <= 32'h0003_1234;
      p1_b <= 16'hDEAD;
      if (cs_b && wn_b && addr_b == 3'd4) p1_b <= lat_b[15:0];
      if (cs_b && wn_b && addr_b == 3'd5) p1_b <= lat_b[31:16];
      p2_b <= p1_b;
      rd_b <= p2_b;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] log_a[$], log_b[$];
  int          logc_a[$], logc_b[$];
  int          ticks_a = 0, svs_a = 0, svs_b = 0;
  always @(negedge clk) begin
    if (cs_a) begin log_a.push_back({~wn_a, addr_a, wd_a}); logc_a.push_back(cyc); end
    if (cs_b) begin log_b.push_back({~wn_b, addr_b, wd_b}); logc_b.push_back(cyc); end
    if (tick_a) ticks_a++;
    if (sv_a) svs_a++;
    if (sv_b) svs_b++;
  end

  int checks = 0, errors = 0;

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cs_a, wn_a, addr_a, wd_a} !== {1'b0, 1'b1, 3'd0, 16'd0}) begin
      errors++; $display("FAIL reset_bus got %h exp %h", {cs_a, wn_a, addr_a, wd_a}, {1'b0, 1'b1, 3'd0, 16'd0});
    end
    checks++;
    if ({tick_a, tcnt_a, sv_a, sval_a, run_a} !== 51'd0) begin
      errors++; $display("FAIL reset_outs got %h exp 0", {tick_a, tcnt_a, sv_a, sval_a, run_a});
    end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) cyc1();
    stop_a = 1'b1; cyc1(); stop_a = 1'b0;
    repeat (6) cyc1();
    checks++;
    if (log_a.size() != 0 || run_a !== 1'b0) begin
      errors++; $display("FAIL idle_stop got accesses=%0d running=%b exp 0/0", log_a.size(), run_a);
    end
  endtask

  task automatic test_program();
    logic [19:0] exp [3] = '{{1'b1, 3'd2, 16'hA11F}, {1'b1, 3'd3, 16'h0007}, {1'b1, 3'd1, 16'h0007}};
    log_a.delete(); logc_a.delete();
    start_a = 1'b1; period_a = 32'h0007_A11F; cyc1(); start_a = 1'b0;
    repeat (6) cyc1();
    checks++;
    if (log_a.size() != 3) begin errors++; $display("FAIL prog_count got %0d exp 3", log_a.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= log_a.size() || log_a[i] !== exp[i]) begin
        errors++; $display("FAIL prog_access%0d got %h exp %h", i, (i < log_a.size()) ? log_a[i] : 20'hxxxxx, exp[i]);
      end
    end
    checks++;
    if (log_a.size() != 3 || logc_a[1] - logc_a[0] != 1 || logc_a[2] - logc_a[1] != 1) begin
      errors++; $display("FAIL prog_consecutive got size %0d exp 3 back-to-back cycles", log_a.size());
    end
    checks++;
    if (run_a !== 1'b1 || tcnt_a !== 16'd0) begin
      errors++; $display("FAIL prog_state got running=%b count=%0d exp 1/0", run_a, tcnt_a);
    end
  endtask

  task automatic test_irq_ticks();
    int t0 = ticks_a;
    log_a.delete(); logc_a.delete();
    for (int k = 0; k < 3; k++) begin
      irq_set = 1'b1; cyc1(); irq_set = 1'b0;
      repeat (5) cyc1();
    end
    checks++;
    if (log_a.size() != 3) begin errors++; $display("FAIL irq_acks got %0d exp 3", log_a.size()); end
    for (int i = 0; i < log_a.size(); i++) begin
      checks++;
      if (log_a[i] !== {1'b1, 3'd0, 16'd0}) begin
        errors++; $display("FAIL irq_ack%0d got %h exp %h", i, log_a[i], {1'b1, 3'd0, 16'd0});
      end
    end
    checks++;
    if (ticks_a - t0 != 3) begin errors++; $display("FAIL tick_pulses got %0d exp 3", ticks_a - t0); end
    checks++;
    if (tcnt_a !== 16'd3) begin errors++; $display("FAIL tick_count got %0d exp 3", tcnt_a); end
  endtask

  task automatic test_snapshot();
    logic [19:0] exp [3] = '{{1'b1, 3'd4, 16'h0}, {1'b0, 3'd4, 16'h0}, {1'b0, 3'd5, 16'h0}};
    int s0 = svs_a;
    log_a.delete(); logc_a.delete();
    snapreq_a = 1'b1; cyc1(); snapreq_a = 1'b0;
    repeat (8) cyc1();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= log_a.size() || log_a[i] !== exp[i]) begin
        errors++; $display("FAIL snap1_access%0d got %h exp %h", i, (i < log_a.size()) ? log_a[i] : 20'hxxxxx, exp[i]);
      end
    end
    checks++;
    if (log_a.size() != 3 || logc_a[2] - logc_a[1] != 2) begin
      errors++; $display("FAIL snap1_gap got size %0d exp 3 accesses, read gap 2", log_a.size());
    end
    checks++;
    if (sval_a !== 32'h0003_1234) begin errors++; $display("FAIL snap1_value got %h exp 00031234", sval_a); end
    checks++;
    if (svs_a - s0 != 1 || run_a !== 1'b1) begin
      errors++; $display("FAIL snap1_valid got pulses=%0d running=%b exp 1/1", svs_a - s0, run_a);
    end
  endtask

  task automatic test_snapshot_rl3();
    logic [19:0] exp [3] = '{{1'b1, 3'd4, 16'h0}, {1'b0, 3'd4, 16'h0}, {1'b0, 3'd5, 16'h0}};
    log_b.delete(); logc_b.delete();
    snapreq_b = 1'b1; cyc1(); snapreq_b = 1'b0;
    repeat (14) cyc1();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= log_b.size() || log_b[i] !== exp[i]) begin
        errors++; $display("FAIL snap3_access%0d got %h exp %h", i, (i < log_b.size()) ? log_b[i] : 20'hxxxxx, exp[i]);
      end
    end
    checks++;
    if (log_b.size() != 3 || logc_b[2] - logc_b[1] != 4) begin
      errors++; $display("FAIL snap3_gap got size %0d exp 3 accesses, read gap 4", log_b.size());
    end
    checks++;
    if (sval_b !== 32'h0003_1234 || svs_b != 1) begin
      errors++; $display("FAIL snap3_value got %h pulses=%0d exp 00031234/1", sval_b, svs_b);
    end
    checks++;
    if (run_b !== 1'b0) begin errors++; $display("FAIL snap3_running got %b exp 0", run_b); end
  endtask

  task automatic test_irq_stop();
    int t0 = ticks_a;
    log_a.delete(); logc_a.delete();
    irq_set = 1'b1; cyc1(); irq_set = 1'b0;
    stop_a = 1'b1; cyc1(); stop_a = 1'b0;
    repeat (6) cyc1();
    checks++;
    if (log_a.size() != 1 || log_a[0] !== {1'b1, 3'd1, 16'h0008}) begin
      errors++; $display("FAIL stop_access got size %0d first %h exp 1 x %h", log_a.size(),
                         (log_a.size() > 0) ? log_a[0] : 20'hxxxxx, {1'b1, 3'd1, 16'h0008});
    end
    checks++;
    if (ticks_a != t0 || run_a !== 1'b0) begin
      errors++; $display("FAIL stop_state got ticks=%0d running=%b exp 0/0", ticks_a - t0, run_a);
    end
    reset_n = 1'b0; cyc1(); reset_n = 1'b1; cyc1();
  endtask

  task automatic test_pend_snap();
    logic [19:0] exp [7] = '{{1'b1, 3'd2, 16'h0010}, {1'b1, 3'd3, 16'h0000}, {1'b1, 3'd1, 16'h0007},
                             {1'b1, 3'd0, 16'h0000}, {1'b1, 3'd4, 16'h0000}, {1'b0, 3'd4, 16'h0000},
                             {1'b0, 3'd5, 16'h0000}};
    int s0 = svs_a;
    log_a.delete(); logc_a.delete();
    cnt_model = 32'h0005_BEEF;
    start_a = 1'b1; period_a = 32'h0000_0010; cyc1(); start_a = 1'b0;
    cyc1();
    snapreq_a = 1'b1; irq_set = 1'b1; cyc1(); snapreq_a = 1'b0; irq_set = 1'b0;
    repeat (12) cyc1();
    checks++;
    if (log_a.size() != 7) begin errors++; $display("FAIL pend_count got %0d exp 7", log_a.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= log_a.size() || log_a[i] !== exp[i]) begin
        errors++; $display("FAIL pend_access%0d got %h exp %h", i, (i < log_a.size()) ? log_a[i] : 20'hxxxxx, exp[i]);
      end
    end
    checks++;
    if (tcnt_a !== 16'd1 || sval_a !== 32'h0005_BEEF || svs_a - s0 != 1 || run_a !== 1'b1) begin
      errors++; $display("FAIL pend_state got count=%0d snap=%h pulses=%0d running=%b exp 1/0005beef/1/1",
                         tcnt_a, sval_a, svs_a - s0, run_a);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        snapreq_a = 1'b1; cyc1(); snapreq_a = 1'b0;
      end else begin
        start_a = 1'b1; period_a = 32'h0000_0100; cyc1(); start_a = 1'b0;
        repeat (4) cyc1();
        irq_set = 1'b1; cyc1(); irq_set = 1'b0;
      end
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (pass == 0) found = cs_a && wn_a && addr_a == 3'd4;
        else           found = cs_a && !wn_a && addr_a == 3'd0 && tick_a;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL areset%0d_reach got timeout exp target access", pass); end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({cs_a, wn_a, addr_a, wd_a, tick_a, tcnt_a, sv_a, sval_a, run_a} !==
          {1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0}) begin
        errors++; $display("FAIL areset%0d_outs got cs=%b wn=%b a=%0d wd=%h tick=%b cnt=%0d sv=%b snap=%h run=%b exp idle zeros",
                           pass, cs_a, wn_a, addr_a, wd_a, tick_a, tcnt_a, sv_a, sval_a, run_a);
      end
      log_a.delete(); logc_a.delete();
      repeat (3) cyc1();
      reset_n = 1'b1;
      repeat (6) cyc1();
      checks++;
      if (log_a.size() != 0) begin errors++; $display("FAIL areset%0d_quiet got %0d accesses exp 0", pass, log_a.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_irq_ticks();
    test_snapshot();
    test_snapshot_rl3();
    test_irq_stop();
    test_pend_snap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
